// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state encoding and frame constants for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular byte FIFO with occupancy count, sync active-high reset.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (pop_i)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= data_i;
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign full_o  = (r_count == CNT_FULL);
  assign empty_o = (r_count == '0);
  assign level_o = r_count;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-fed 8N1 UART transmitter, LSB first at CLK_FREQ/BAUD clocks per bit.
// Optional even parity (8E1) when UART_TX_PARITY_EN is defined.
import uart_pkg::*;

module uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx: CLK_FREQ / BAUD must be at least 2");
    end
  endgenerate

  uart_tx_state_e            r_state;
  uart_tx_state_e            w_state_next;
  logic [CW-1:0]             r_cnt;
  logic [CW-1:0]             w_cnt_next;
  logic [BW-1:0]             r_bit;
  logic [BW-1:0]             w_bit_next;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_next;
  logic                      r_tx;
  logic                      w_tx_next;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_period_done;
  logic [UART_DATA_BITS-1:0] w_head;
  logic [$clog2(FIFO_DEPTH):0] w_level;

  assign w_push = valid_i && !w_full;

  uart_tx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (data_i),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  // Captured at pop time, since the shift register is drained by the time PARITY runs.
  always_ff @(posedge clk_i) begin
    if (rst_i)      r_parity <= 1'b0;
    else if (w_pop) r_parity <= ^w_head;
  end
`endif

  assign w_period_done = (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    w_tx_next    = 1'b1;

    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_cnt_next   = '0;
          w_bit_next   = '0;
          w_state_next = START;
        end
      end
      START: begin
        if (w_period_done) begin
          w_cnt_next   = '0;
          w_state_next = DATA;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (w_period_done) begin
          w_cnt_next   = '0;
          w_shift_next = {1'b0, r_shift[UART_DATA_BITS-1:1]};
          if (r_bit == BIT_LAST) begin
            w_bit_next = '0;
`ifdef UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_bit_next = r_bit + BIT_ONE;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_period_done) begin
          w_cnt_next   = '0;
          w_state_next = STOP;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (w_period_done) begin
          w_cnt_next = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_head;
            w_bit_next   = '0;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
        w_bit_next   = '0;
      end
    endcase

    // The line is registered, so it is driven from the state being entered.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_next = r_parity;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  assign tx_o    = r_tx;
  assign ready_o = !w_full;
  assign level_o = w_level;
  assign busy_o  = (r_state != IDLE) || (w_level != '0);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx: stimulus queues expected bytes, a line monitor decodes and checks.
// Parity checks are enabled when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * DIV;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       tx_o;
  logic       busy_o;
  logic [4:0] level_o;

  uart_tx #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .level_o (level_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];
  int         starts[$];
  int         last_start = 0;
  logic [7:0] last_rx = 8'h00;
  logic       last_par = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: reference receiver sampling every cycle on the falling edge.
  logic       in_frame = 1'b0;
  int         k = 0;
  logic       cur = 1'b1;
  logic       bad = 1'b0;
  logic       stop_v = 1'b0;
  logic       par_v = 1'b0;
  logic [7:0] rx = 8'h00;
  logic [7:0] exp_b;

  always @(negedge clk_i) begin
    if (rst_i) begin
      in_frame = 1'b0;
      sb.delete();
    end else begin
      if (!in_frame && tx_o == 1'b0) begin
        in_frame = 1'b1;
        k = 0;
        bad = 1'b0;
        last_start = cyc;
        starts.push_back(cyc);
      end
      if (in_frame) begin
        if (k % DIV == 0) cur = tx_o;
        else if (tx_o !== cur) bad = 1'b1;
        if (k % DIV == DIV - 1) begin
          if (k / DIV >= 1 && k / DIV <= 8) rx[k / DIV - 1] = cur;
          else if (FRAME_BITS == 11 && k / DIV == 9) par_v = cur;
          if (k / DIV == FRAME_BITS - 1) stop_v = cur;
        end
        k++;
        if (k == FRAME_CYC) begin
          in_frame = 1'b0;
          last_rx = rx;
          last_par = par_v;
          check("bit_stable", bad, 1'b0);
          check("stop_bit", stop_v, 1'b1);
          check("frame_expected", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            exp_b = sb.pop_front();
            check("rx_byte", rx, exp_b);
            if (FRAME_BITS == 11) check("rx_parity", par_v, ^exp_b);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, output int acc);
    int n = 0;
    data_i = b;
    valid_i = 1'b1;
    @(negedge clk_i);
    while (!ready_o && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) check("send_timeout", ready_o, 1'b1);
    else sb.push_back(b);
    @(posedge clk_i);
    #1;
    acc = cyc;
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(output int fall);
    int n = 0;
    @(negedge clk_i);
    while (busy_o && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    check("idle_timeout", busy_o, 1'b0);
    fall = cyc;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int acc, acc0, fall, e, idx, guard, s;
    logic accepted;

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      check("idle_state", {tx_o, busy_o, ready_o, level_o}, {1'b1, 1'b0, 1'b1, 5'd0});
    end
    @(posedge clk_i);
    #1;

    // 2: single byte 'A'
    send(8'h41, acc);
    check("level_after_push", level_o, 5'd1);
    wait_idle(fall);
    check("start_latency", last_start, acc + 1);
    check("busy_fall", fall, last_start + FRAME_CYC);
    check("rx_A", last_rx, 8'h41);

    // 3: back-to-back frames
    starts.delete();
    send(8'h55, acc);
    send(8'hAA, acc);
    wait_idle(fall);
    check("b2b_frames", starts.size(), 2);
    if (starts.size() == 2) begin
      check("b2b_gap", starts[1] - starts[0], FRAME_CYC);
      check("b2b_busy_fall", fall, starts[0] + 2 * FRAME_CYC);
    end
    check("rx_AA", last_rx, 8'hAA);

    // 4: hold valid with 20 bytes, FIFO fills and drains one slot per frame
    e = -1;
    idx = 0;
    guard = 0;
    data_i = 8'h00;
    valid_i = 1'b1;
    while (idx < 20 && guard < 3000) begin
      @(negedge clk_i);
      if (e == 1)   check("push_pop_level", level_o, 5'd1);
      if (e == 15)  check("level15_ready", {level_o, ready_o}, {5'd15, 1'b1});
      if (e == 16)  check("full_ready_low", {level_o, ready_o}, {5'd16, 1'b0});
      if (e == 100) check("full_hold", level_o, 5'd16);
      if (e == 101) check("pop_frees_slot", {level_o, ready_o}, {5'd15, 1'b1});
      if (e == 102) check("refill", level_o, 5'd16);
      accepted = ready_o;
      if (accepted) sb.push_back(idx[7:0]);
      @(posedge clk_i);
      e++;
      guard++;
      #1;
      if (accepted) begin
        idx++;
        data_i = idx[7:0];
      end
    end
    valid_i = 1'b0;
    check("stream_all_accepted", idx, 20);
    wait_idle(fall);
    check("rx_last_stream", last_rx, 8'h13);
    check("stream_sb_drained", sb.size(), 0);

    // 5: reset in data bit 3 with 5 bytes queued
    send(8'hC3, acc0);
    for (int i = 1; i <= 5; i++) send(8'(8'h10 + i), acc);
    s = acc0 + 1;
    check("queued_five", level_o, 5'd5);
    repeat (s + 44 - cyc) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_mid_frame", {tx_o, level_o, busy_o, ready_o}, {1'b1, 5'd0, 1'b0, 1'b1});
    @(posedge clk_i);
    #1;
    send(8'h7E, acc);
    wait_idle(fall);
    check("post_reset_start", last_start, acc + 1);
    check("rx_7E", last_rx, 8'h7E);

`ifdef UART_TX_PARITY_EN
    // 6: even parity
    send(8'h07, acc);
    wait_idle(fall);
    check("par_frame_len", fall - last_start, 110);
    check("par_07", last_par, 1'b1);
    send(8'h03, acc);
    wait_idle(fall);
    check("par_03", last_par, 1'b0);
`endif

    check("sb_empty_end", sb.size(), 0);
    check("monitor_idle_end", in_frame, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
